// File: rtl/data_array_init_ctrl_pkg.sv
// Shared types and default widths for the data-array init/access controller.
package data_array_init_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF = 10;
  localparam int unsigned DATA_W_DEF = 8;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/data_array_init_ctrl_resp.sv
// Read-response capture: bypasses macro data in the first response cycle,
// then holds it stable while the consumer stalls.
module data_array_init_ctrl_resp
  import data_array_init_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_rd_accept,
  input  logic              i_resp_ready,
  input  logic [DATA_W-1:0] i_ram_rdata,
  output logic              o_resp_valid,
  output logic [DATA_W-1:0] o_resp_rdata
);

  logic              r_valid;
  logic              r_first;
  logic [DATA_W-1:0] r_hold;

  // r_first marks the cycle in which the macro output belongs to our read.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_valid <= 1'b0;
      r_first <= 1'b0;
      r_hold  <= '0;
    end else begin
      r_valid <= i_rd_accept | (r_valid & ~i_resp_ready);
      r_first <= i_rd_accept;
      if (r_first) begin
        r_hold <= i_ram_rdata;
      end
    end
  end

  assign o_resp_valid = r_valid;
  assign o_resp_rdata = r_first ? i_ram_rdata : r_hold;

endmodule

// File: rtl/data_array_init_ctrl.sv
// Front-end for a single-port data-array macro: fills the array after reset or
// on request, then maps a valid/ready request channel onto macro cycles.
module data_array_init_ctrl
  import data_array_init_ctrl_pkg::*;
#(
  parameter int unsigned     ADDR_W = ADDR_W_DEF,
  parameter int unsigned     DATA_W = DATA_W_DEF,
  parameter int unsigned     DEPTH  = 1 << ADDR_W,
  parameter logic [DATA_W-1:0] FILL = '0
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_init_start,
  output logic              o_init_busy,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_write,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  input  logic              i_req_wmask,
  output logic              o_resp_valid,
  input  logic              i_resp_ready,
  output logic [DATA_W-1:0] o_resp_rdata,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  output logic              o_ram_en,
  output logic              o_ram_wmode,
  output logic              o_ram_wmask,
  input  logic [DATA_W-1:0] i_ram_rdata
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             w_sweep_last;
  logic             w_resp_valid;
  logic             w_stall;
  logic             w_accept;
  logic             w_rd_accept;

  assign w_sweep_last = (r_cnt == CNT_W'(DEPTH - 1));
  assign w_stall      = w_resp_valid & ~i_resp_ready;
  assign o_resp_valid = w_resp_valid;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A re-init request is dropped while a response is still outstanding.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_INIT: if (w_sweep_last) w_state_nxt = ST_RUN;
      ST_RUN:  if (i_init_start && !w_resp_valid) w_state_nxt = ST_INIT;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // Sweep address; parked at zero in RUN so every sweep starts at address 0.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cnt <= '0;
    end else if (r_state == ST_INIT) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= '0;
    end
  end

  // Macro writes on en&wmask, so wmask stays low on every read and idle cycle.
  always_comb begin
    o_init_busy = 1'b0;
    o_req_ready = 1'b0;
    o_ram_en    = 1'b0;
    o_ram_wmode = 1'b0;
    o_ram_wmask = 1'b0;
    o_ram_addr  = i_req_addr;
    o_ram_wdata = i_req_wdata;
    w_accept    = 1'b0;
    w_rd_accept = 1'b0;
    unique case (r_state)
      ST_INIT: begin
        o_init_busy = 1'b1;
        o_ram_en    = 1'b1;
        o_ram_wmode = 1'b1;
        o_ram_wmask = 1'b1;
        o_ram_addr  = r_cnt[ADDR_W-1:0];
        o_ram_wdata = FILL;
      end
      ST_RUN: begin
        o_req_ready = ~w_stall & ~i_init_start;
        w_accept    = i_req_valid & o_req_ready;
        w_rd_accept = w_accept & ~i_req_write;
        o_ram_en    = w_accept;
        o_ram_wmode = w_accept & i_req_write;
        o_ram_wmask = w_accept & i_req_write & i_req_wmask;
      end
      default: begin
        o_init_busy = 1'b1;
      end
    endcase
    if (!i_reset_n) begin
      o_ram_en    = 1'b0;
      o_ram_wmask = 1'b0;
    end
  end

  data_array_init_ctrl_resp #(
    .DATA_W (DATA_W)
  ) u_resp (
    .i_clock      (i_clock),
    .i_reset_n    (i_reset_n),
    .i_rd_accept  (w_rd_accept),
    .i_resp_ready (i_resp_ready),
    .i_ram_rdata  (i_ram_rdata),
    .o_resp_valid (w_resp_valid),
    .o_resp_rdata (o_resp_rdata)
  );

endmodule

// File: tb/tb_data_array_init_ctrl.sv
// Scoreboard bench for data_array_init_ctrl with a behavioural 1024x8 macro.
module tb_data_array_init_ctrl;

  localparam int unsigned AW    = 10;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 1024;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          init_start;
  logic          init_busy;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          req_wmask;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_en;
  logic          ram_wmode;
  logic          ram_wmask;
  logic [DW-1:0] ram_rdata;

  logic [DW-1:0] mem [DEPTH];
  logic          preload;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] mon_exp;

  always #5 clock = ~clock;

  data_array_init_ctrl dut (
    .i_clock      (clock),
    .i_reset_n    (reset_n),
    .i_init_start (init_start),
    .o_init_busy  (init_busy),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_write  (req_write),
    .i_req_addr   (req_addr),
    .i_req_wdata  (req_wdata),
    .i_req_wmask  (req_wmask),
    .o_resp_valid (resp_valid),
    .i_resp_ready (resp_ready),
    .o_resp_rdata (resp_rdata),
    .o_ram_addr   (ram_addr),
    .o_ram_wdata  (ram_wdata),
    .o_ram_en     (ram_en),
    .o_ram_wmode  (ram_wmode),
    .o_ram_wmask  (ram_wmask),
    .i_ram_rdata  (ram_rdata)
  );

  // Macro model: read port always enabled, write whenever en & wmask.
  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'hEE;
    end else begin
      ram_rdata <= mem[ram_addr];
      if (ram_en && ram_wmask) mem[ram_addr] <= ram_wdata;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Response monitor: pops the scoreboard on every response handshake.
  always @(negedge clock) begin
    if (reset_n && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        check("resp_unexpected", 32'(resp_rdata), 32'hFFFF_FFFF);
      end else begin
        mon_exp = exp_q.pop_front();
        check("resp_rdata", 32'(resp_rdata), 32'(mon_exp));
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clock);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
    if (!ok) check("req_ready_timeout", 32'(0), 32'(1));
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic m);
    bit ok;
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d; req_wmask = m;
    wait_ready(ok);
    cyc();
    req_valid = 1'b0; req_write = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] e);
    bit ok;
    req_valid = 1'b1; req_write = 1'b0; req_addr = a;
    wait_ready(ok);
    check("rd_macro_ctrl", 32'({ram_en, ram_wmode, ram_wmask}), 32'(3'b100));
    if (ok) exp_q.push_back(e);
    cyc();
    req_valid = 1'b0;
    @(negedge clock);
    check("rd_latency", 32'(resp_valid), 32'(1));
    cyc();
  endtask

  // Checks a full sweep starting in the current cycle and RUN entry after it.
  task automatic sweep_check(input string tag);
    int bad;
    bad = -1;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clock);
      if (bad < 0 && !(ram_en && ram_wmode && ram_wmask && ram_addr == AW'(i) &&
                       ram_wdata == 8'h00 && init_busy && !req_ready))
        bad = i;
      @(posedge clock);
    end
    #1;
    check({tag, "_first_bad_cycle"}, 32'(bad), 32'hFFFF_FFFF);
    @(negedge clock);
    check({tag, "_ready_at_1024"}, 32'(req_ready), 32'(1));
    check({tag, "_busy_at_1024"}, 32'(init_busy), 32'(0));
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int nz;
    reset_n = 1'b0; preload = 1'b1; init_start = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wmask = 1'b0;
    resp_ready = 1'b1;
    @(posedge clock);
    #1 preload = 1'b0;
    @(negedge clock);
    check("reset_outputs",
          32'({ram_en, ram_wmask, init_busy, req_ready, resp_valid, resp_rdata}),
          32'({1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00}));
    cyc();
    reset_n = 1'b1;
    sweep_check("boot_sweep");
    nz = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] != 8'h00) nz++;
    check("boot_sweep_nonzero_words", 32'(nz), 32'(0));

    wr(10'h3FF, 8'h5A, 1'b1);
    rd(10'h3FF, 8'h5A);

    wr(10'd7, 8'h11, 1'b1);
    wr(10'd7, 8'h99, 1'b0);
    rd(10'd7, 8'h11);

    wr(10'd5, 8'h6B, 1'b1);
    rd(10'd5, 8'h6B);
    rd(10'd5, 8'h6B);

    // Backpressure: response must hold while the macro address moves on.
    wr(10'd2, 8'hC3, 1'b1);
    resp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 10'd2;
    wait_ready(ok);
    if (ok) exp_q.push_back(8'hC3);
    cyc();
    begin
      int berr;
      berr = 0;
      for (int s = 0; s < 5; s++) begin
        req_addr = AW'(100 + s);
        @(negedge clock);
        if (!resp_valid || resp_rdata != 8'hC3 || req_ready || ram_en || ram_wmask ||
            ram_addr != AW'(100 + s))
          berr++;
        cyc();
      end
      check("backpressure_bad_cycles", 32'(berr), 32'(0));
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(negedge clock);
    cyc();

    // init_start while a response is pending is dropped.
    resp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 10'd2;
    wait_ready(ok);
    if (ok) exp_q.push_back(8'hC3);
    cyc();
    req_valid = 1'b0;
    init_start = 1'b1;
    @(negedge clock);
    check("init_pending_ready", 32'(req_ready), 32'(0));
    cyc();
    init_start = 1'b0;
    resp_ready = 1'b1;
    @(negedge clock);
    check("init_ignored_busy", 32'(init_busy), 32'(0));
    cyc();

    // Read then write of the same address on consecutive cycles.
    wr(10'd3, 8'h33, 1'b1);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 10'd3;
    wait_ready(ok);
    if (ok) exp_q.push_back(8'h33);
    cyc();
    req_write = 1'b1; req_wdata = 8'h44; req_wmask = 1'b1;
    @(negedge clock);
    check("b2b_write_ready", 32'(req_ready), 32'(1));
    cyc();
    req_valid = 1'b0; req_write = 1'b0;
    rd(10'd3, 8'h44);

    // Re-init, then reset in the middle of the sweep.
    wr(10'd9, 8'hFF, 1'b1);
    rd(10'd9, 8'hFF);
    init_start = 1'b1;
    @(negedge clock);
    check("init_start_blocks_ready", 32'(req_ready), 32'(0));
    cyc();
    init_start = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 1100; k++) begin
      @(negedge clock);
      if (k == 0) check("reinit_first_addr", 32'({init_busy, ram_addr}), 32'({1'b1, 10'd0}));
      if (init_busy && ram_addr == 10'd500) begin
        ok = 1'b1;
        break;
      end
    end
    check("reinit_reached_500", 32'(ok), 32'(1));
    reset_n = 1'b0;
    #1;
    check("midsweep_reset_outputs", 32'({ram_en, ram_wmask, init_busy, req_ready}),
          32'({1'b0, 1'b0, 1'b1, 1'b0}));
    cyc();
    reset_n = 1'b1;
    sweep_check("restart_sweep");
    rd(10'd9, 8'h00);
    rd(10'h3FF, 8'h00);

    repeat (2) cyc();
    check("scoreboard_left", 32'(exp_q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
